// File: rtl/codec_cfg_pkg.sv
// Shared constants for the WM8731 3-wire configuration sequencer.
// Optional single-write port is enabled by CODEC_CFG_WRITE_PORT_EN.
package codec_cfg_pkg;

    localparam int WORD_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [6:0] REG_R0  = 7'd0;
    localparam logic [6:0] REG_R1  = 7'd1;
    localparam logic [6:0] REG_R2  = 7'd2;
    localparam logic [6:0] REG_R3  = 7'd3;
    localparam logic [6:0] REG_R4  = 7'd4;
    localparam logic [6:0] REG_R5  = 7'd5;
    localparam logic [6:0] REG_R6  = 7'd6;
    localparam logic [6:0] REG_R7  = 7'd7;
    localparam logic [6:0] REG_R8  = 7'd8;
    localparam logic [6:0] REG_R9  = 7'd9;
    localparam logic [6:0] REG_R15 = 7'd15;

    // Power-up order: reset first, activate last.
    localparam logic [0:15][WORD_W-1:0] CFG_TABLE = '{
        {REG_R15, 9'h000},
        {REG_R6,  9'h010},
        {REG_R0,  9'h017},
        {REG_R1,  9'h017},
        {REG_R2,  9'h079},
        {REG_R3,  9'h079},
        {REG_R4,  9'h012},
        {REG_R5,  9'h000},
        {REG_R7,  9'h002},
        {REG_R9,  9'h001},
        16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000
    };

    function automatic logic [WORD_W-1:0] cfg_word(input logic [3:0] i);
        return CFG_TABLE[i];
    endfunction

endpackage

// File: rtl/codec_cmd_shifter.sv
// 16-bit load/shift-left command register; MSB drives the codec data pin.
// Shifting in zeros leaves the register cleared after a full word.
module codec_cmd_shifter
    import codec_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              msb_o
);

    logic [WORD_W-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= word_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[WORD_W-2:0], 1'b0};
        end
    end

    assign msb_o = sr_q[WORD_W-1];

endmodule

// File: rtl/codec_cfg_seq.sv
// WM8731 3-wire power-up configuration sequencer.
// Define CODEC_CFG_WRITE_PORT_EN to add the single-word user write port.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int N_REGS  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  idx,
    output logic        sclk,
    output logic        sdin,
    output logic        csb
`ifdef CODEC_CFG_WRITE_PORT_EN
    ,
    input  logic        wr_req,
    input  logic [15:0] wr_word,
    output logic        wr_ack
`endif
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST   = 4'(N_REGS - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic       half_q, half_d;
    logic [3:0] idx_q, idx_d;
    logic       sclk_q, sclk_d;
    logic       csb_q, csb_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ld, sh;
    logic [WORD_W-1:0] ld_word;
`ifdef CODEC_CFG_WRITE_PORT_EN
    logic       usr_q, usr_d;
    logic       ack_q, ack_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        half_d  = half_q;
        idx_d   = idx_q;
        sclk_d  = sclk_q;
        csb_d   = csb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        sh      = 1'b0;
        ld_word = cfg_word(idx_q);
`ifdef CODEC_CFG_WRITE_PORT_EN
        usr_d   = usr_q;
        ack_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                csb_d  = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = 4'd0;
                    ld      = 1'b1;
                    ld_word = cfg_word(4'd0);
                    csb_d   = 1'b0;
                    busy_d  = 1'b1;
`ifdef CODEC_CFG_WRITE_PORT_EN
                    usr_d   = 1'b0;
                end else if (wr_req) begin
                    state_d = ST_LOAD;
                    ld      = 1'b1;
                    ld_word = wr_word;
                    csb_d   = 1'b0;
                    busy_d  = 1'b1;
                    usr_d   = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                cnt_d   = 8'd0;
                half_d  = 1'b0;
                bit_d   = 4'd0;
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d = 8'd0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        sclk_d = 1'b1;
                    end else begin
                        // Shift on the falling SCLK edge keeps SDIN centred on the rise.
                        sh     = 1'b1;
                        half_d = 1'b0;
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = ST_LATCH;
                            csb_d   = 1'b1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_LATCH: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d = 8'd0;
`ifdef CODEC_CFG_WRITE_PORT_EN
                    if (usr_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        ack_d   = 1'b1;
                        usr_d   = 1'b0;
                    end else
`endif
                    if (idx_q == LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_LOAD;
                        ld      = 1'b1;
                        ld_word = cfg_word(idx_q + 4'd1);
                        csb_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            half_q  <= 1'b0;
            idx_q   <= 4'd0;
            sclk_q  <= 1'b0;
            csb_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            idx_q   <= idx_d;
            sclk_q  <= sclk_d;
            csb_q   <= csb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CODEC_CFG_WRITE_PORT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            usr_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            usr_q <= usr_d;
            ack_q <= ack_d;
        end
    end

    assign wr_ack = ack_q;
`endif

    codec_cmd_shifter u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ld),
        .shift_i (sh),
        .word_i  (ld_word),
        .msb_o   (sdin)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign idx  = idx_q;
    assign sclk = sclk_q;
    assign csb  = csb_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Directed bench for codec_cfg_seq (CLK_DIV=2, N_REGS=10).
// Write-port steps are built when CODEC_CFG_WRITE_PORT_EN is defined.
module tb_codec_cfg_seq;

    localparam int CLK_DIV = 2;
    localparam int N_REGS  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, sclk, sdin, csb;
    logic [3:0] idx;
`ifdef CODEC_CFG_WRITE_PORT_EN
    logic        wr_req = 1'b0;
    logic [15:0] wr_word = 16'h0000;
    logic        wr_ack;
`endif

    always #5 clk = ~clk;

    codec_cfg_seq #(.CLK_DIV(CLK_DIV), .N_REGS(N_REGS)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .idx     (idx),
        .sclk    (sclk),
        .sdin    (sdin),
        .csb     (csb)
`ifdef CODEC_CFG_WRITE_PORT_EN
        ,
        .wr_req  (wr_req),
        .wr_word (wr_word),
        .wr_ack  (wr_ack)
`endif
    );

    logic [15:0] exp_tab [10] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217,
                                  16'h0479, 16'h0679, 16'h0812, 16'h0A00,
                                  16'h0E02, 16'h1201};

    int checks = 0;
    int errors = 0;

    // Pin monitor: rebuilds frames from SDIN on each SCLK rise
    int          n_sck = 0, n_csb = 0, n_done = 0, n_ack = 0, wbits = 0;
    logic [15:0] shreg = 16'h0;
    logic [15:0] words [64];
    logic        sclk_p = 1'b0, csb_p = 1'b1;

    always @(negedge clk) begin
        if (sclk === 1'b1 && sclk_p === 1'b0) begin
            n_sck <= n_sck + 1;
            shreg <= {shreg[14:0], sdin};
            wbits <= wbits + 1;
        end
        if (csb === 1'b1 && csb_p === 1'b0) begin
            if (n_csb < 64) words[n_csb[5:0]] <= shreg;
            n_csb <= n_csb + 1;
            shreg <= 16'h0;
            wbits <= 0;
        end
        if (done === 1'b1) n_done <= n_done + 1;
`ifdef CODEC_CFG_WRITE_PORT_EN
        if (wr_ack === 1'b1) n_ack <= n_ack + 1;
`endif
        sclk_p <= sclk;
        csb_p  <= csb;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc, input int k0);
        cyc = -1;
        for (int k = k0 + 1; k <= k0 + 3000; k++) begin
            tick();
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic chk_table(input string tag, input int base);
        int mm;
        mm = 0;
        for (int i = 0; i < N_REGS; i++)
            if (words[base + i] !== exp_tab[i]) mm++;
        chk(tag, mm, 0);
    endtask

    int b_sck, b_csb, b_done, cyc, bad;
    logic got;

    initial begin
        // Reset and idle
        repeat (3) tick();
        chk("rst_csb", csb, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdin", sdin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", idx, 0);
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (csb !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || idx !== 4'd0) bad++;
        end
        chk("idle_hold", bad, 0);

        // Single start pulse: full table
        b_sck = n_sck;
        b_csb = n_csb;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("seq1_busy", busy, 1);
        chk("seq1_csb_low", csb, 0);
        chk("seq1_idx", idx, 0);
        wait_done(cyc, 1);
        chk("seq1_done_cycle", cyc, 671);
        chk("seq1_idx_last", idx, 9);
        tick();
        chk("seq1_done_width", done, 0);
        chk("seq1_busy_off", busy, 0);
        chk("seq1_sclk_rises", n_sck - b_sck, 160);
        chk("seq1_csb_rises", n_csb - b_csb, 10);
        chk("seq1_word0", words[b_csb], 16'h1E00);
        chk("seq1_word9", words[b_csb + 9], 16'h1201);
        chk_table("seq1_table", b_csb);

        // start held high through a whole sequence
        repeat (3) tick();
        b_csb  = n_csb;
        b_done = n_done;
        start  = 1'b1;
        wait_done(cyc, 0);
        chk("held_done_cycle", cyc, 671);
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("held_busy_off", busy, 0);
        chk("held_csb_high", csb, 1);
        chk("held_idx", idx, 9);
        chk("held_csb_rises", n_csb - b_csb, 10);
        chk("held_done_count", n_done - b_done, 1);

        // Second start one cycle after done
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, 1);
        chk("b2b_first_cycle", cyc, 671);
        tick();
        b_csb = n_csb;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_idx", idx, 0);
        chk("b2b_csb_low", csb, 0);
        wait_done(cyc, 1);
        chk("b2b_done_cycle", cyc, 671);
        tick();
        chk_table("b2b_table", b_csb);

        // Reset during bit 7 of word 3, then restart
        repeat (3) tick();
        b_csb = n_csb;
        start = 1'b1;
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (n_csb - b_csb == 3 && wbits == 8) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_reach_bit7", got, 1);
        chk("mid_idx_before", idx, 3);
        reset = 1'b1;
        tick();
        chk("mid_csb", csb, 1);
        chk("mid_busy", busy, 0);
        chk("mid_idx", idx, 0);
        chk("mid_sclk", sclk, 0);
        reset = 1'b0;
        repeat (3) tick();
        b_csb = n_csb;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_restart_idx", idx, 0);
        wait_done(cyc, 1);
        chk("mid_done_cycle", cyc, 671);
        tick();
        chk("mid_csb_rises", n_csb - b_csb, 10);
        chk_table("mid_table", b_csb);

`ifdef CODEC_CFG_WRITE_PORT_EN
        // Single user write
        repeat (3) tick();
        b_sck  = n_sck;
        b_csb  = n_csb;
        b_done = n_done;
        wr_word = 16'h0C1F;
        wr_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("wr_busy", busy, 1);
        got = 1'b0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (wr_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("wr_ack_seen", got, 1);
        repeat (4) tick();
        chk("wr_frame", words[b_csb], 16'h0C1F);
        chk("wr_csb_rises", n_csb - b_csb, 1);
        chk("wr_sclk_rises", n_sck - b_sck, 16);
        chk("wr_ack_count", n_ack, 1);
        chk("wr_no_done", n_done - b_done, 0);
        chk("wr_idx_kept", idx, 9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
